// File: rtl/sdram_wb_arbiter.sv
// Round-robin arbiter that shares the single sdram_wish_if master port among N_PORTS requesters.
// One single-word access is in flight at a time; the winner gets read data and a done/err pulse.
module sdram_wb_arbiter #(
  parameter int N_PORTS       = 4,
  parameter int AW            = 32,
  parameter int DW            = 16,
  parameter int START_TIMEOUT = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N_PORTS-1:0]    m_req_i,
  input  logic [N_PORTS-1:0]    m_we_i,
  input  logic [N_PORTS*AW-1:0] m_addr_i,
  input  logic [N_PORTS*DW-1:0] m_wdat_i,
  output logic [N_PORTS-1:0]    m_ack_o,
  output logic [N_PORTS-1:0]    m_err_o,
  output logic [DW-1:0]         m_rdat_o,
  output logic [N_PORTS-1:0]    m_gnt_o,
  output logic [AW-1:0]         s_addr_o,
  output logic [DW-1:0]         s_dat_o,
  output logic                  s_we_o,
  output logic                  s_stb_o,
  input  logic                  s_cyc_i,
  input  logic [DW-1:0]         s_dat_i
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    ACK
  } state_t;

  state_t        state;
  logic [PW-1:0] last;
  logic [PW-1:0] winner;
  logic          found;
  logic [CW-1:0] cnt;

  // Search last+1, last+2, ... (mod N_PORTS) for the first pending request.
  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 1; i <= N_PORTS; i++) begin
      int idx;
      idx = (int'(last) + i) % N_PORTS;
      if (!found && m_req_i[idx[PW-1:0]]) begin
        found  = 1'b1;
        winner = idx[PW-1:0];
      end
    end
  end

  // NOTE: all state and outputs use non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      last     <= PW'(N_PORTS - 1);
      cnt      <= '0;
      m_ack_o  <= '0;
      m_err_o  <= '0;
      m_rdat_o <= '0;
      m_gnt_o  <= '0;
      s_addr_o <= '0;
      s_dat_o  <= '0;
      s_we_o   <= 1'b0;
      s_stb_o  <= 1'b0;
    end else begin
      // Pulse outputs default low and are raised only for the cycle that needs them.
      m_ack_o <= '0;
      m_err_o <= '0;
      s_stb_o <= 1'b0;
      case (state)
        IDLE: begin
          if (found && !s_cyc_i) begin
            s_addr_o <= m_addr_i[int'(winner)*AW +: AW];
            s_dat_o  <= m_wdat_i[int'(winner)*DW +: DW];
            s_we_o   <= m_we_i[winner];
            m_gnt_o  <= N_PORTS'(1) << winner;
            last     <= winner;
            s_stb_o  <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_START;
        end
        WAIT_START: begin
          if (s_cyc_i) begin
            state <= WAIT_DONE;
          end else if (cnt == CW'(START_TIMEOUT - 2)) begin
            // ACK lands exactly START_TIMEOUT cycles after the strobe cycle.
            m_err_o <= m_gnt_o;
            state   <= ACK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_DONE: begin
          if (!s_cyc_i) begin
            if (!s_we_o) m_rdat_o <= s_dat_i;
            m_ack_o <= m_gnt_o;
            state   <= ACK;
          end
        end
        ACK: begin
          m_gnt_o <= '0;
          s_we_o  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Self-checking bench for sdram_wb_arbiter: directed scenarios plus randomized rounds,
// checked against a transaction-level round-robin / memory reference model.
module tb_sdram_wb_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int TO = 8;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [N-1:0]    m_req_i, m_we_i;
  logic [N*AW-1:0] m_addr_i;
  logic [N*DW-1:0] m_wdat_i;
  logic [N-1:0]    m_ack_o, m_err_o, m_gnt_o;
  logic [DW-1:0]   m_rdat_o;
  logic [AW-1:0]   s_addr_o;
  logic [DW-1:0]   s_dat_o, s_dat_i;
  logic            s_we_o, s_stb_o, s_cyc_i;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  sdram_wb_arbiter #(.N_PORTS(N), .AW(AW), .DW(DW), .START_TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i), .m_wdat_i(m_wdat_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rdat_o(m_rdat_o), .m_gnt_o(m_gnt_o),
    .s_addr_o(s_addr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_stb_o(s_stb_o),
    .s_cyc_i(s_cyc_i), .s_dat_i(s_dat_i)
  );

  always #10 clk_i = ~clk_i;
  always @(posedge clk_i) cyc_cnt++;

  // SDRAM controller model: raises cyc the cycle after a strobe, stays busy for
  // busy_cycles cycles and presents read data as cyc falls.
  logic            ext_busy;
  logic            ctl_dead;
  int              busy_cycles;
  logic            ctl_cyc;
  int              busy_left;
  logic [AW-1:0]   op_addr;
  logic            op_we;
  logic [DW-1:0]   dev_mem [logic [AW-1:0]];

  assign s_cyc_i = ctl_cyc | ext_busy;

  function automatic logic [DW-1:0] dev_read(input logic [AW-1:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : (a[DW-1:0] ^ 16'h5A5A);
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctl_cyc   <= 1'b0;
      busy_left <= 0;
      s_dat_i   <= '0;
    end else if (ctl_cyc) begin
      if (busy_left <= 1) begin
        ctl_cyc <= 1'b0;
        if (!op_we) s_dat_i <= dev_read(op_addr);
      end else begin
        busy_left <= busy_left - 1;
      end
    end else if (s_stb_o && !ctl_dead) begin
      ctl_cyc   <= 1'b1;
      busy_left <= busy_cycles;
      op_addr   <= s_addr_o;
      op_we     <= s_we_o;
      s_dat_i   <= 16'hDEAD;
      if (s_we_o) dev_mem[s_addr_o] = s_dat_o;
    end
  end

  // Reference model state
  int            last_m;
  logic [DW-1:0] exp_mem [logic [AW-1:0]];
  logic [DW-1:0] exp_rdat;
  int            grant_log[$];
  int            last_stb_cyc;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : (a[DW-1:0] ^ 16'h5A5A);
  endfunction

  function automatic int rr_pick(input logic [N-1:0] mask, input int last);
    for (int i = 1; i <= N; i++)
      if (mask[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_we_i[p]           = we;
    m_addr_i[p*AW +: AW] = a;
    m_wdat_i[p*DW +: DW] = d;
  endtask

  // Waits for n_acc completions, checking each against the model. Returns at the
  // negedge of the last ACK cycle so the caller can drop requests in time.
  task automatic serve(input int n_acc, input bit keep);
    for (int k = 0; k < n_acc; k++) begin
      int            exp_port, obs_port, stb_seen, stb_cyc;
      bit            got, dead;
      logic [AW-1:0] s_a, p_a;
      logic [DW-1:0] s_d, p_d;
      logic          s_w, p_w;
      logic [N-1:0]  s_g, onehot;
      exp_port = rr_pick(m_req_i, last_m);
      p_w = (exp_port >= 0) ? m_we_i[exp_port] : 1'b0;
      p_a = (exp_port >= 0) ? m_addr_i[exp_port*AW +: AW] : '0;
      p_d = (exp_port >= 0) ? m_wdat_i[exp_port*DW +: DW] : '0;
      onehot = (exp_port >= 0) ? N'(1 << exp_port) : '0;
      stb_seen = 0; stb_cyc = 0; got = 0;
      s_a = '0; s_d = '0; s_w = 1'b0; s_g = '0;
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clk_i);
        if (s_stb_o) begin
          stb_seen++; stb_cyc = cyc_cnt;
          s_a = s_addr_o; s_d = s_dat_o; s_w = s_we_o; s_g = m_gnt_o;
        end
        if (|m_ack_o || |m_err_o) got = 1;
      end
      check("ack_within_budget", 64'(got), 64'd1);
      if (!got) return;
      dead = ctl_dead;
      last_stb_cyc = stb_cyc;
      obs_port = -1;
      for (int i = 0; i < N; i++) if (m_ack_o[i] || m_err_o[i]) obs_port = i;
      grant_log.push_back(obs_port);
      check("winner", 64'(obs_port), 64'(exp_port));
      check(dead ? "err_vec" : "ack_vec", dead ? m_err_o : m_ack_o, onehot);
      check("no_ack_err_overlap", dead ? m_ack_o : m_err_o, '0);
      check("gnt_at_ack", m_gnt_o, onehot);
      check("stb_count", 64'(stb_seen), 64'd1);
      check("gnt_at_stb", s_g, onehot);
      check("addr_at_stb", s_a, p_a);
      check("we_at_stb", s_w, p_w);
      if (p_w) check("wdat_at_stb", s_d, p_d);
      check("latency", 64'(cyc_cnt - stb_cyc), dead ? 64'(TO) : 64'(busy_cycles + 2));
      if (!dead) begin
        if (p_w) begin
          exp_mem[p_a] = p_d;
          check("rdat_hold_on_write", m_rdat_o, exp_rdat);
        end else begin
          exp_rdat = mem_val(p_a);
          check("rdat", m_rdat_o, exp_rdat);
        end
      end
      last_m = exp_port;
      if (!keep && exp_port >= 0) m_req_i[exp_port] = 1'b0;
    end
  endtask

  initial begin
    int  rel_cyc;
    bit  seen;
    logic [N-1:0] mask;

    rst_ni = 1'b0; m_req_i = '0; m_we_i = '0; m_addr_i = '0; m_wdat_i = '0;
    ext_busy = 1'b0; ctl_dead = 1'b0; busy_cycles = 2;
    last_m = N - 1; exp_rdat = '0;
    dev_mem[32'h100] = 16'hBEEF; exp_mem[32'h100] = 16'hBEEF;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("reset_port_outs", {m_ack_o, m_err_o, m_gnt_o, m_rdat_o}, '0);
    check("reset_sdram_outs", {s_addr_o, s_dat_o, s_we_o, s_stb_o}, '0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Fairness: all ports request continuously for 8 accesses
    for (int p = 0; p < N; p++) set_port(p, 1'b0, 32'h200 + 32'(p), '0);
    m_req_i = '1;
    grant_log.delete();
    serve(8, 1'b1);
    m_req_i = '0;
    for (int i = 0; i < 8; i++)
      check($sformatf("fair_order_%0d", i), 64'(i < grant_log.size() ? grant_log[i] : -1), 64'(i % N));

    // Single write: port 0 writes 0x1234 to 0x20
    @(negedge clk_i);
    set_port(0, 1'b1, 32'h20, 16'h1234);
    m_req_i = 4'b0001;
    serve(1, 1'b0);
    check("dev_mem_write", dev_mem.exists(32'h20) ? dev_mem[32'h20] : 16'h0, 16'h1234);

    // Single read: port 1 reads 0x100 with 6 busy cycles
    @(negedge clk_i);
    busy_cycles = 6;
    set_port(1, 1'b0, 32'h100, '0);
    m_req_i = 4'b0010;
    serve(1, 1'b0);
    check("read_beef", m_rdat_o, 16'hBEEF);

    // Timeout on one requester, then the other is served normally
    @(negedge clk_i);
    busy_cycles = 2;
    ctl_dead = 1'b1;
    set_port(1, 1'b1, 32'h30, 16'h5555);
    set_port(2, 1'b0, 32'h31, '0);
    m_req_i = 4'b0110;
    serve(1, 1'b0);
    ctl_dead = 1'b0;
    serve(1, 1'b0);

    // Busy hold-off: no grant while cyc is held high externally
    @(negedge clk_i);
    ext_busy = 1'b1;
    set_port(2, 1'b0, 32'h44, '0);
    m_req_i = 4'b0100;
    repeat (5) begin
      @(negedge clk_i);
      check("holdoff_no_gnt", m_gnt_o, '0);
    end
    ext_busy = 1'b0;
    rel_cyc = cyc_cnt;
    serve(1, 1'b0);
    check("holdoff_grant_delay", 64'(last_stb_cyc - rel_cyc), 64'd1);

    // Randomized rounds
    for (int r = 0; r < 8; r++) begin
      @(negedge clk_i);
      busy_cycles = $urandom_range(1, 5);
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int p = 0; p < N; p++)
        set_port(p, 1'($urandom_range(0, 1)), 32'h40 + 32'($urandom_range(0, 7)), 16'($urandom));
      m_req_i = mask;
      serve($countones(mask), 1'b0);
    end

    // Reset mid-access: port 1 in WAIT_DONE, then ports 0 and 2 after release
    @(negedge clk_i);
    busy_cycles = 10;
    set_port(1, 1'b0, 32'h300, '0);
    m_req_i = 4'b0010;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk_i);
      if (s_stb_o) seen = 1;
    end
    check("midreset_stb_seen", 64'(seen), 64'd1);
    repeat (3) @(negedge clk_i);
    check("midreset_busy", s_cyc_i, 1'b1);
    check("midreset_gnt", m_gnt_o, 4'b0010);
    #2 rst_ni = 1'b0;
    m_req_i = '0;
    #1;
    check("midreset_port_outs", {m_ack_o, m_err_o, m_gnt_o, m_rdat_o}, '0);
    check("midreset_sdram_outs", {s_addr_o, s_dat_o, s_we_o, s_stb_o}, '0);
    last_m = N - 1; exp_rdat = '0;
    repeat (2) begin
      @(negedge clk_i);
      check("midreset_no_pulse", {m_ack_o, m_err_o}, '0);
    end
    rst_ni = 1'b1;
    busy_cycles = 3;
    set_port(0, 1'b0, 32'h20, '0);
    set_port(2, 1'b1, 32'h22, 16'hA0A0);
    m_req_i = 4'b0101;
    grant_log.delete();
    serve(2, 1'b0);
    check("post_reset_first", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd0);

    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
